// File: rtl/alu_share_arb.sv
// Round-robin shared ALU with a single-entry operand slot and valid/ready response.
// Define ALU_ARB_STATS_EN to build per-requester grant counters.
module alu_share_arb #(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*3-1:0]  req_ctrl,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    resp_valid,
  output logic [31:0]        resp_result,
  output logic [3:0]         resp_flags,
  input  logic [NREQ-1:0]    resp_ready,
  input  logic               stat_clr,
  output logic [NREQ*16-1:0] stat_grants
);

  localparam int PW = $clog2(NREQ);

  logic [31:0]   sa, sb;
  logic [2:0]    sc;
  logic [PW-1:0] own, ptr, gidx, gsel;
  logic          slot_full, slot_free;
  logic          gfound, take;

  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0] p,
    input int            k
  );
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // first valid requester at or after ptr, with wrap
  always_comb begin
    gfound = 1'b0;
    gidx   = '0;
    gsel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      gsel = wrap(ptr, k);
      if (!gfound && req_valid[gsel]) begin
        gfound = 1'b1;
        gidx   = gsel;
      end
    end
  end

  assign slot_free = ~slot_full | resp_ready[own];
  assign take      = ~reset & slot_free & gfound;

  always_comb begin
    req_ready       = '0;
    req_ready[gidx] = take;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_full <= 1'b0;
      ptr       <= '0;
      own       <= '0;
      sa        <= '0;
      sb        <= '0;
      sc        <= '0;
    end else if (take) begin
      sa        <= req_a[32*gidx +: 32];
      sb        <= req_b[32*gidx +: 32];
      sc        <= req_ctrl[3*gidx +: 3];
      own       <= gidx;
      slot_full <= 1'b1;
      ptr       <= (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);
    end else if (slot_full & resp_ready[own]) begin
      slot_full <= 1'b0;
    end
  end

  logic        arith, sub, cf, vf, vis;
  logic [31:0] bop, res;
  logic [32:0] sum;

  always_comb begin
    arith = (sc == 3'b000) | (sc == 3'b001) | (sc == 3'b111);
    sub   = (sc == 3'b001);
    bop   = sub ? ~sb : sb;
    sum   = {1'b0, sa} + {1'b0, bop} + {32'd0, sub};
    case (sc)
      3'b010:  res = sa & sb;
      3'b011:  res = sa | sb;
      3'b100:  res = sa & ~sb;
      3'b101:  res = sa ^ sb;
      3'b110:  res = sb;
      default: res = sum[31:0];
    endcase
    cf = arith & sum[32];
    vf = arith & ~(sa[31] ^ sb[31] ^ sub) & (sa[31] ^ sum[31]);
  end

  // outputs read zero whenever no response is pending
  assign vis = slot_full & ~reset;

  always_comb begin
    resp_valid      = '0;
    resp_valid[own] = vis;
    resp_result     = vis ? res : 32'd0;
    resp_flags      = vis ? {res[31], res == 32'd0, cf, vf} : 4'd0;
  end

`ifdef ALU_ARB_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
      if (reset | stat_clr)
        cnt <= '0;
      else if (req_ready[i] && cnt != 16'hFFFF)
        cnt <= cnt + 16'd1;
    end
    assign stat_grants[16*i +: 16] = cnt;
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_grants     = '0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed plus random bench for alu_share_arb against a transaction-level model.
// Stats expectations follow ALU_ARB_STATS_EN.
module tb_alu_share_arb;

  localparam int N = 2;
`ifdef ALU_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk, reset, stat_clr;
  logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [N*32-1:0] req_a, req_b;
  logic [N*3-1:0]  req_ctrl;
  logic [31:0]     resp_result;
  logic [3:0]      resp_flags;
  logic [N*16-1:0] stat_grants;

  alu_share_arb #(.NREQ(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ctrl(req_ctrl), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_result(resp_result),
    .resp_flags(resp_flags), .resp_ready(resp_ready),
    .stat_clr(stat_clr), .stat_grants(stat_grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          m_full;
  int          m_own, m_ptr, last_grant;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_c;
  int          m_cnt [N];
  logic [31:0] held;

  function automatic logic [35:0] ref_alu(
    input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic        cf, vf;
    cf = 1'b0;
    vf = 1'b0;
    case (c)
      3'b001: begin
        s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r  = s[31:0];
        cf = s[32];
        vf = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a & ~b;
      3'b101: r = a ^ b;
      3'b110: r = b;
      default: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[31:0];
        cf = s[32];
        vf = (a[31] == b[31]) && (r[31] != a[31]);
      end
    endcase
    return {r[31], r == 32'd0, cf, vf, r};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  // check outputs for the current inputs, advance the model, cross one edge
  task automatic cyc();
    logic [N-1:0] er, ev;
    logic [35:0]  eo;
    bit           sf;
    int           g;
    #1;
    ev = '0;
    eo = '0;
    if (!reset && m_full) begin
      ev[m_own] = 1'b1;
      eo = ref_alu(m_a, m_b, m_c);
    end
    sf = !reset && (!m_full || resp_ready[m_own]);
    g = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (g < 0 && req_valid[i]) g = i;
    end
    er = '0;
    if (sf && g >= 0) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("resp_valid", resp_valid, ev);
    chk("resp_result", resp_result, eo[31:0]);
    chk("resp_flags", resp_flags, eo[35:32]);
    for (int i = 0; i < N; i++)
      chk("stat_grants", stat_grants[16*i +: 16], STATS ? m_cnt[i] : 0);
    last_grant = (sf && g >= 0) ? g : -1;
    if (reset) begin
      m_full = 1'b0;
      m_ptr  = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      if (stat_clr)
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      else if (last_grant >= 0 && m_cnt[g] < 65535)
        m_cnt[g]++;
      if (last_grant >= 0) begin
        m_a    = req_a[32*g +: 32];
        m_b    = req_b[32*g +: 32];
        m_c    = req_ctrl[3*g +: 3];
        m_own  = g;
        m_full = 1'b1;
        m_ptr  = (g + 1) % N;
      end else if (m_full && resp_ready[m_own]) begin
        m_full = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] c);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_ctrl[3*i +: 3] = c;
  endtask

  task automatic rnd_ops();
    for (int i = 0; i < N; i++)
      set_op(i, rnd_op(), rnd_op(), 3'($urandom_range(0, 7)));
  endtask

  initial begin
    m_full = 0; m_own = 0; m_ptr = 0; last_grant = -1;
    m_a = '0; m_b = '0; m_c = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    reset = 1'b1; stat_clr = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_ctrl = '0;
    resp_ready = '0;
    @(negedge clk);
    cyc();
    reset = 1'b0;

    // single subtract
    resp_ready = 2'b11;
    req_valid = 2'b01;
    set_op(0, 32'd5, 32'd3, 3'b001);
    cyc();
    chk("single_grant", last_grant, 0);
    chk("single_valid", resp_valid, 2'b01);
    chk("single_result", resp_result, 32'h2);
    chk("single_flags", resp_flags, 4'b0010);

    // signed overflow then carry-out to zero
    req_valid = 2'b10;
    set_op(1, 32'h7FFF_FFFF, 32'd1, 3'b000);
    cyc();
    chk("ovf_valid", resp_valid, 2'b10);
    chk("ovf_result", resp_result, 32'h8000_0000);
    chk("ovf_flags", resp_flags, 4'b1001);
    set_op(1, 32'hFFFF_FFFF, 32'd1, 3'b000);
    cyc();
    chk("zc_result", resp_result, 32'h0);
    chk("zc_flags", resp_flags, 4'b0110);

    // round robin after reset
    req_valid = 2'b00;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      rnd_ops();
      cyc();
      chk("rr_grant", last_grant, k % 2);
      chk("rr_owner", resp_valid, 2'b01 << (k % 2));
    end

    // backpressure on owner 0
    rnd_ops();
    cyc();
    chk("bp_grant", last_grant, 0);
    held = resp_result;
    resp_ready = 2'b10;
    for (int k = 0; k < 3; k++) begin
      rnd_ops();
      cyc();
      chk("bp_nogrant", last_grant, -1);
      chk("bp_valid", resp_valid, 2'b01);
      chk("bp_hold", resp_result, held);
    end
    resp_ready = 2'b11;
    cyc();
    chk("bp_release", last_grant, 1);
    chk("bp_next", resp_valid, 2'b10);

    // reset while stalled
    resp_ready = 2'b00;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_valid", resp_valid, 2'b00);
    resp_ready = 2'b11;
    cyc();
    chk("rst_first", last_grant, 0);

    // grant counters
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    req_valid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      rnd_ops();
      cyc();
    end
    chk("stat_five", stat_grants[31:16], STATS ? 16'd5 : 16'd0);
    stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0;
    chk("stat_clr", stat_grants[31:16], 16'd0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      req_valid  = N'($urandom);
      resp_ready = N'($urandom) | N'($urandom);
      stat_clr   = ($urandom_range(0, 31) == 0);
      reset      = ($urandom_range(0, 99) == 0);
      rnd_ops();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Shares one 32-bit ALU (add/sub/and/orr/bic/eor/mov, NZCV flags) between NREQ requesters, e.g. the execute stage plus multi-cycle helper units, in the ARM pipeline processor. It runs round-robin arbitration over valid/ready request channels and registers the granted operation into a single-entry operand slot. It drives the ALU from that slot and returns result and flags to the issuing requester over a valid/ready response channel with backpressure.

## Interface
- `NREQ`, default 2: number of requesters, legal range 2..4.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NREQ: request i presents an operation.
- `req_a` in NREQ*32: operand A; requester i occupies bits [32i+31:32i].
- `req_b` in NREQ*32: operand B, same packing as `req_a`.
- `req_ctrl` in NREQ*3: ALU control; 000 add, 001 sub, 010 and, 011 orr, 100 bic (a&~b), 101 eor, 110 mov b, 111 treated as add.
- `req_ready` out NREQ: request i is accepted this cycle when `req_valid[i] & req_ready[i]`.
- `resp_valid` out NREQ: one-hot; marks the owner of the pending response.
- `resp_result` out 32: shared result bus.
- `resp_flags` out 4: {N,Z,C,V}.
- `resp_ready` in NREQ: per-requester response accept.
- `stat_clr` in 1: clears statistics counters (see Configuration).
- `stat_grants` out NREQ*16: per-requester accepted-op counters.

## Operation
- State: operand slot (a, b, ctrl, owner index), `slot_full` bit, round-robin pointer `ptr` (0..NREQ-1).
- `slot_free = ~slot_full | resp_ready[owner]`.
- Grant is combinational: the first i with `req_valid[i]`, searching from `ptr` upward with wrap.
- `req_ready[i] = slot_free & grant[i]`. At most one bit of `req_ready` is high. `req_ready` depends on `req_valid`; requesters must not make valid depend on ready.
- On accept from i:
  - Capture operands and owner into the slot.
  - Set `slot_full`.
  - Set `ptr <= (i+1) mod NREQ`.
- On response handshake with no new accept: clear `slot_full`.
- Handshake and accept in the same cycle: the slot is refilled and stays full. No bubble.
- `resp_valid = slot_full ? onehot(owner) : 0`.
- `resp_result` and `resp_flags` are combinational from the slot:
  - Sub is a + ~b + 1 over 33 bits.
  - C = bit 32 for add/sub, else 0.
  - V = ~(a31^b31^ctrl0) & (a31^sum31) for add/sub, else 0.
  - N = result[31]. Z = (result == 0).
- While the response stalls, the slot and outputs hold stable. The operand values of a non-granted requester are ignored.
- Reset values: `slot_full`=0, `ptr`=0, slot registers=0, `resp_valid`=0, `resp_result`=0, `resp_flags`=0000, `req_ready`=0 during the reset cycle, `stat_grants`=0.
- Reset mid-operation discards the pending response. No handshake completes in the reset cycle.

## Timing
- Latency: accept at edge N; `resp_valid` high in cycle N+1 with final result and flags.
- Throughput: 1 op/cycle while the owner holds `resp_ready` high.
- Fairness: with all requesters continuously valid and no backpressure, each requester is served once every NREQ cycles.
- `ptr` advances only on accept. Stall cycles do not rotate priority.

## Configuration
- `ALU_ARB_STATS_EN` defined:
  - `stat_grants[i]` increments by 1 on each accept from i and saturates at 0xFFFF.
  - `stat_clr` zeroes all counters next edge and takes priority over a same-cycle increment.
- Not defined: `stat_grants` is tied to 0, `stat_clr` is ignored, and no counter flops exist.
- Ports are identical in both builds.

## Test plan
- Single op: req0 a=5, b=3, ctrl=001, `resp_ready`=11 -> next cycle `resp_valid`=01, result=0x00000002, flags=0010.
- Overflow and flags: req1 a=0x7FFFFFFF, b=1, ctrl=000 -> result=0x80000000, flags=1001. Then a=0xFFFFFFFF, b=1, add -> result 0, flags 0110.
- Round-robin: both valid for 6 cycles after reset, no backpressure -> grant order 0,1,0,1,0,1. `resp_valid` owner tracks each grant one cycle later.
- Backpressure: `resp_ready[0]`=0 for 3 cycles with both requesters valid -> `req_ready`=00 and the response is stable. On release, the handshake plus the new accept (req1) happen in the same cycle.
- Reset mid-operation: slot full and stalled, assert `reset` 1 cycle -> `resp_valid`=00 and `ptr`=0. First grant after reset goes to req0.
- Stats (with macro): 5 accepts from req1 -> `stat_grants[31:16]`=5. Assert `stat_clr` with a simultaneous accept -> 0. Without the macro, `stat_grants` stays 0.
